// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared definitions for the pipeline control unit.
// Purpose : memory wait-state FSM encodings, the legal SRAM latency range,
//           and the packed bundle of stage-register control outputs.
// Ports   : none (package).
package pipe_ctrl_unit_pkg;

    // Wait-state FSM encodings, kept as plain constants so older tools can read them
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Wait cycles must fit the 4-bit down-counter and be at least one
    localparam int SRAM_LAT_MIN = 1;
    localparam int SRAM_LAT_MAX = 15;

    function automatic bit sram_lat_ok(input int lat);
        return (lat >= SRAM_LAT_MIN) && (lat <= SRAM_LAT_MAX);
    endfunction

    // Every load/flush/select line driven toward the datapath
    typedef struct packed {
        logic pc_ld;
        logic pc_sel_br;
        logic if_id_ld;
        logic if_id_flush;
        logic id_exe_ld;
        logic id_exe_flush;
        logic exe_mem_ld;
        logic mem_wb_ld;
        logic sr_ld;
    } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_unit_sram_wait_fsm.sv
// Memory wait-state sequencer.
// Purpose : freezes the pipeline while a MEM-stage SRAM access completes.
//           IDLE opens an access, BUSY counts the wait cycles down, DONE
//           lets the pipeline advance for exactly one cycle.
// Ports   : clk, rst        - clock and synchronous active-high reset
//           mem_r_en/w_en   - MEM-stage load/store request
//           sram_start      - one-cycle pulse opening an access
//           mem_busy        - stall request toward the control mux
module pipe_ctrl_unit_sram_wait_fsm
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int SRAM_LAT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_r_en,
    input  logic mem_w_en,
    output logic sram_start,
    output logic mem_busy
);

    localparam logic [3:0] LAT_INIT = 4'(SRAM_LAT - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_req;

    assign mem_req = mem_r_en | mem_w_en;

    // Next-state and outputs. Reset overrides everything so an access in
    // flight is abandoned and no new pulse escapes while reset is held.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sram_start = 1'b0;
        mem_busy   = 1'b0;
        if (rst) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_req) begin
                        sram_start = 1'b1;
                        mem_busy   = 1'b1;
                        cnt_d      = LAT_INIT;
                        state_d    = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    mem_busy = 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                // The request is still visible here, but this is the cycle
                // the stalled instruction leaves MEM, so it must not restart.
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Central stall/flush sequencer for the 5-stage pipeline around EXE.
// Purpose : RAW hazard detection, branch flushes, and memory wait-state
//           freezing; drives stage-register ld/flush, PC and status loads.
// Ports   : clk, rst                  - clock, synchronous active-high reset
//           fwd_en                    - forwarding active (only load-use stalls)
//           id_src1/src2, id_use_src1, id_two_src - ID source operands
//           exe_dest, exe_wb_en, exe_mem_r_en, exe_s, exe_br_taken - EXE info
//           mem_dest, mem_wb_en, mem_r_en, mem_w_en - MEM info
//           pc_ld, pc_sel_br, *_ld, *_flush, sr_ld   - datapath controls
//           sram_start, mem_busy      - SRAM handshake and stall indication
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int SRAM_LAT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fwd_en,
    input  logic [3:0] id_src1,
    input  logic [3:0] id_src2,
    input  logic       id_use_src1,
    input  logic       id_two_src,
    input  logic [3:0] exe_dest,
    input  logic       exe_wb_en,
    input  logic       exe_mem_r_en,
    input  logic       exe_s,
    input  logic       exe_br_taken,
    input  logic [3:0] mem_dest,
    input  logic       mem_wb_en,
    input  logic       mem_r_en,
    input  logic       mem_w_en,
    output logic       pc_ld,
    output logic       pc_sel_br,
    output logic       if_id_ld,
    output logic       if_id_flush,
    output logic       id_exe_ld,
    output logic       id_exe_flush,
    output logic       exe_mem_ld,
    output logic       mem_wb_ld,
    output logic       sr_ld,
    output logic       sram_start,
    output logic       mem_busy
);

    if (!sram_lat_ok(SRAM_LAT)) begin : g_bad_lat
        $error("pipe_ctrl_unit: SRAM_LAT must be within 1..15");
    end

    logic  hz_exe, hz_mem, hazard;
    ctrl_t ctrl;

    pipe_ctrl_unit_sram_wait_fsm #(.SRAM_LAT(SRAM_LAT)) u_wait_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .sram_start (sram_start),
        .mem_busy   (mem_busy)
    );

    // RAW compare against the two younger-than-WB producers. With forwarding
    // only a load in EXE cannot be bypassed in time, so only that one stalls.
    always_comb begin
        hz_exe = exe_wb_en & ((id_use_src1 & (exe_dest == id_src1)) |
                              (id_two_src  & (exe_dest == id_src2)));
        hz_mem = mem_wb_en & ((id_use_src1 & (mem_dest == id_src1)) |
                              (id_two_src  & (mem_dest == id_src2)));
        hazard = fwd_en ? (hz_exe & exe_mem_r_en) : (hz_exe | hz_mem);
    end

    // Priority mux: reset > memory busy > branch > hazard > run.
    // A branch outranks a hazard because the hazarded instruction is
    // being flushed anyway; a branch held during a stall waits for DONE.
    always_comb begin
        ctrl = '{pc_ld: 1'b1, pc_sel_br: 1'b0, if_id_ld: 1'b1, if_id_flush: 1'b0,
                 id_exe_ld: 1'b1, id_exe_flush: 1'b0, exe_mem_ld: 1'b1,
                 mem_wb_ld: 1'b1, sr_ld: 1'b0};
        if (!rst) begin
            if (mem_busy) begin
                ctrl = '0;
            end else begin
                ctrl.sr_ld = exe_s;
                if (exe_br_taken) begin
                    ctrl.pc_sel_br    = 1'b1;
                    ctrl.if_id_flush  = 1'b1;
                    ctrl.id_exe_flush = 1'b1;
                end else if (hazard) begin
                    ctrl.pc_ld        = 1'b0;
                    ctrl.if_id_ld     = 1'b0;
                    ctrl.id_exe_flush = 1'b1;
                end
            end
        end
    end

    assign pc_ld        = ctrl.pc_ld;
    assign pc_sel_br    = ctrl.pc_sel_br;
    assign if_id_ld     = ctrl.if_id_ld;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_exe_ld    = ctrl.id_exe_ld;
    assign id_exe_flush = ctrl.id_exe_flush;
    assign exe_mem_ld   = ctrl.exe_mem_ld;
    assign mem_wb_ld    = ctrl.mem_wb_ld;
    assign sr_ld        = ctrl.sr_ld;

endmodule
